dc_port_arbiter: RTL and testbench

Shares the single data-cache request port between two requesters: r0, the Mem stage load/store path, and r1, a secondary agent such as a store-drain or debug port. It sits between the pipeline's memory-side agents and the data cache. It latches the winning request, drives the dc_* interface until dc_ack, then returns read data and a one-cycle ack to the winner. Arbitration is round-robin, so neither requester starves.

---
 rtl/dc_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_dc_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_port_arbiter.sv
// Two-requester round-robin arbiter for the data-cache request port.
// Optional ack timeout is built only with `define DC_TIMEOUT_EN.
module dc_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic [57:0] r0_line_addr,
  input  logic [2:0]  r0_word_select,
  input  logic [2:0]  r0_byte_offset,
  input  logic [63:0] r0_wdata,
  input  logic        r0_read_write_n,
  input  logic [1:0]  r0_store_type,
  output logic        r0_ack,
  output logic [63:0] r0_rdata,
  input  logic        r1_req,
  input  logic [57:0] r1_line_addr,
  input  logic [2:0]  r1_word_select,
  input  logic [2:0]  r1_byte_offset,
  input  logic [63:0] r1_wdata,
  input  logic        r1_read_write_n,
  input  logic [1:0]  r1_store_type,
  output logic        r1_ack,
  output logic [63:0] r1_rdata,
  output logic        dc_req,
  output logic [57:0] dc_line_addr,
  output logic [2:0]  dc_word_select,
  output logic [2:0]  dc_byte_offset,
  output logic [63:0] dc_data_to_cache,
  output logic        dc_read_write_n,
  output logic [1:0]  store_type,
  input  logic        dc_ack,
  input  logic [63:0] dc_data_from_cache,
  output logic        busy,
  output logic        grant_id,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [57:0] la_q, la_d;
  logic [2:0]  ws_q, ws_d;
  logic [2:0]  bo_q, bo_d;
  logic [63:0] wd_q, wd_d;
  logic        rw_q, rw_d;
  logic [1:0]  st_q, st_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [63:0] rd0_q, rd0_d;
  logic [63:0] rd1_q, rd1_d;
  logic        busy_q, busy_d;
  logic        gid_q, gid_d;
  logic        pick1;

`ifdef DC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TmoLast =
    CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TIMEOUT_CYCLES),
                        32'(CNT_W)};
`endif

  // r1 wins when alone, or on a tie when r0 owned last
  assign pick1 = r1_req & (~r0_req | ~gid_q);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    la_d    = la_q;
    ws_d    = ws_q;
    bo_d    = bo_q;
    wd_d    = wd_q;
    rw_d    = rw_q;
    st_d    = st_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    gid_d   = gid_q;
`ifdef DC_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (r0_req | r1_req) begin
          state_d = ISSUE;
          req_d   = 1'b1;
          gid_d   = pick1;
          la_d    = pick1 ? r1_line_addr
                          : r0_line_addr;
          ws_d    = pick1 ? r1_word_select
                          : r0_word_select;
          bo_d    = pick1 ? r1_byte_offset
                          : r0_byte_offset;
          wd_d    = pick1 ? r1_wdata
                          : r0_wdata;
          rw_d    = pick1 ? r1_read_write_n
                          : r0_read_write_n;
          st_d    = pick1 ? r1_store_type
                          : r0_store_type;
`ifdef DC_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (dc_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          ack0_d  = ~gid_q;
          ack1_d  = gid_q;
          if (rw_q && !gid_q) rd0_d = dc_data_from_cache;
          if (rw_q &&  gid_q) rd1_d = dc_data_from_cache;
        end
`ifdef DC_TIMEOUT_EN
        else if (cnt_q == TmoLast) begin
          state_d = RESP;
          req_d   = 1'b0;
          ack0_d  = ~gid_q;
          ack1_d  = gid_q;
          err_d   = 1'b1;
          if (!gid_q) rd0_d = '0;
          if (gid_q)  rd1_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      la_q    <= '0;
      ws_q    <= '0;
      bo_q    <= '0;
      wd_q    <= '0;
      rw_q    <= 1'b1;
      st_q    <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      busy_q  <= 1'b0;
      gid_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      la_q    <= la_d;
      ws_q    <= ws_d;
      bo_q    <= bo_d;
      wd_q    <= wd_d;
      rw_q    <= rw_d;
      st_q    <= st_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
    end
  end

`ifdef DC_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dc_req           = req_q;
  assign dc_line_addr     = la_q;
  assign dc_word_select   = ws_q;
  assign dc_byte_offset   = bo_q;
  assign dc_data_to_cache = wd_q;
  assign dc_read_write_n  = rw_q;
  assign store_type       = st_q;
  assign r0_ack           = ack0_q;
  assign r1_ack           = ack1_q;
  assign r0_rdata         = rd0_q;
  assign r1_rdata         = rd1_q;
  assign busy             = busy_q;
  assign grant_id         = gid_q;

endmodule

// File: tb/tb_dc_port_arbiter.sv
// Bench for dc_port_arbiter: vector table, hand sequences and
// randomized traffic against a transaction-level model.
module tb_dc_port_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r1_req;
  logic [57:0] r0_line_addr, r1_line_addr;
  logic [2:0]  r0_word_select, r1_word_select;
  logic [2:0]  r0_byte_offset, r1_byte_offset;
  logic [63:0] r0_wdata, r1_wdata;
  logic        r0_read_write_n, r1_read_write_n;
  logic [1:0]  r0_store_type, r1_store_type;
  logic        r0_ack, r1_ack;
  logic [63:0] r0_rdata, r1_rdata;
  logic        dc_req;
  logic [57:0] dc_line_addr;
  logic [2:0]  dc_word_select, dc_byte_offset;
  logic [63:0] dc_data_to_cache;
  logic        dc_read_write_n;
  logic [1:0]  store_type;
  logic        dc_ack;
  logic [63:0] dc_data_from_cache;
  logic        busy, grant_id, err;

  always #5 clk = ~clk;

  dc_port_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_line_addr(r0_line_addr),
    .r0_word_select(r0_word_select),
    .r0_byte_offset(r0_byte_offset),
    .r0_wdata(r0_wdata), .r0_read_write_n(r0_read_write_n),
    .r0_store_type(r0_store_type),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_line_addr(r1_line_addr),
    .r1_word_select(r1_word_select),
    .r1_byte_offset(r1_byte_offset),
    .r1_wdata(r1_wdata), .r1_read_write_n(r1_read_write_n),
    .r1_store_type(r1_store_type),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .dc_req(dc_req), .dc_line_addr(dc_line_addr),
    .dc_word_select(dc_word_select),
    .dc_byte_offset(dc_byte_offset),
    .dc_data_to_cache(dc_data_to_cache),
    .dc_read_write_n(dc_read_write_n),
    .store_type(store_type),
    .dc_ack(dc_ack), .dc_data_from_cache(dc_data_from_cache),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: one open transaction at most,
  // followed by one response cycle.
  logic        e_req, e_rw, e_gid, e_err, e_busy;
  logic [57:0] e_la;
  logic [2:0]  e_ws, e_bo;
  logic [63:0] e_wd;
  logic [1:0]  e_st;
  logic        e_ack[2];
  logic [63:0] e_rd[2];
  bit          m_open, m_done;
  int          m_wait;

  function automatic void model_reset();
    e_req = 0; e_rw = 1; e_gid = 1; e_err = 0; e_busy = 0;
    e_la = '0; e_ws = '0; e_bo = '0; e_wd = '0; e_st = '0;
    e_ack[0] = 0; e_ack[1] = 0;
    e_rd[0] = '0; e_rd[1] = '0;
    m_open = 0; m_done = 0; m_wait = 0;
  endfunction

  function automatic void complete(input logic [63:0] d,
                                   input bit tmo);
    int o;
    o = int'(e_gid);
    e_req = 0;
    m_open = 0;
    m_done = 1;
    e_err = tmo;
    e_ack[o] = 1;
    if (tmo) e_rd[o] = '0;
    else if (e_rw) e_rd[o] = d;
  endfunction

  function automatic void model_step();
    bit w;
    e_ack[0] = 0; e_ack[1] = 0; e_err = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_open) begin
      if (dc_ack) complete(dc_data_from_cache, 0);
      else begin
`ifdef DC_TIMEOUT_EN
        m_wait++;
        if (m_wait == TMO) complete('0, 1);
`endif
      end
    end else if (r0_req || r1_req) begin
      w = (r0_req && r1_req) ? !e_gid : r1_req;
      e_gid = w;
      e_req = 1;
      m_open = 1;
      m_wait = 0;
      e_la = w ? r1_line_addr : r0_line_addr;
      e_ws = w ? r1_word_select : r0_word_select;
      e_bo = w ? r1_byte_offset : r0_byte_offset;
      e_wd = w ? r1_wdata : r0_wdata;
      e_rw = w ? r1_read_write_n : r0_read_write_n;
      e_st = w ? r1_store_type : r0_store_type;
    end
    e_busy = m_open || m_done;
  endfunction

  task automatic check_all();
    chk("dc_req", 64'(dc_req), 64'(e_req));
    chk("dc_line_addr", 64'(dc_line_addr), 64'(e_la));
    chk("dc_word_select", 64'(dc_word_select), 64'(e_ws));
    chk("dc_byte_offset", 64'(dc_byte_offset), 64'(e_bo));
    chk("dc_data_to_cache", dc_data_to_cache, e_wd);
    chk("dc_read_write_n", 64'(dc_read_write_n), 64'(e_rw));
    chk("store_type", 64'(store_type), 64'(e_st));
    chk("r0_ack", 64'(r0_ack), 64'(e_ack[0]));
    chk("r1_ack", 64'(r1_ack), 64'(e_ack[1]));
    chk("r0_rdata", r0_rdata, e_rd[0]);
    chk("r1_rdata", r1_rdata, e_rd[1]);
    chk("busy", 64'(busy), 64'(e_busy));
    chk("grant_id", 64'(grant_id), 64'(e_gid));
    chk("err", 64'(err), 64'(e_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_fields(input logic [57:0] la,
                            input logic [2:0] ws,
                            input logic [2:0] bo,
                            input logic [63:0] wd,
                            input logic rw,
                            input logic [1:0] st);
    r0_line_addr = la; r1_line_addr = la;
    r0_word_select = ws; r1_word_select = ws;
    r0_byte_offset = bo; r1_byte_offset = bo;
    r0_wdata = wd; r1_wdata = wd;
    r0_read_write_n = rw; r1_read_write_n = rw;
    r0_store_type = st; r1_store_type = st;
  endtask

  typedef struct {
    logic        q0, q1, rw;
    logic [1:0]  st;
    logic [57:0] la;
    logic [2:0]  ws;
    logic [63:0] wd;
    int          dly;
    logic [63:0] cdata;
    logic        e_gid;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input int idx, input vec_t v);
    int hi;
    string s;
    s = $sformatf("vec%0d", idx);
    set_fields(v.la, v.ws, 3'd0, v.wd, v.rw, v.st);
    r0_req = v.q0;
    r1_req = v.q1;
    dc_ack = 0;
    cycle();
    chk({s, " grant_id"}, 64'(grant_id), 64'(v.e_gid));
    chk({s, " dc_rw"}, 64'(dc_read_write_n), 64'(v.rw));
    chk({s, " dc_st"}, 64'(store_type), 64'(v.st));
    chk({s, " dc_wdata"}, dc_data_to_cache, v.wd);
    chk({s, " dc_la"}, 64'(dc_line_addr), 64'(v.la));
    hi = 1;
    for (int k = 0; k <= v.dly; k++) begin
      dc_ack = (k == v.dly);
      dc_data_from_cache = v.cdata;
      cycle();
      if (dc_req) hi++;
    end
    chk({s, " req_cycles"}, 64'(hi), 64'(v.dly + 1));
    chk({s, " own_ack"},
        64'(v.e_gid ? r1_ack : r0_ack), 64'd1);
    chk({s, " other_ack"},
        64'(v.e_gid ? r0_ack : r1_ack), 64'd0);
    chk({s, " rdata"},
        v.e_gid ? r1_rdata : r0_rdata, v.e_rdata);
    r0_req = 0;
    r1_req = 0;
    dc_ack = 0;
    cycle();
    chk({s, " ack_drop"}, 64'(r0_ack | r1_ack), 64'd0);
    chk({s, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vt[0] = '{1, 1, 1, 2'd0, 58'h15, 3'd3, 64'h0, 2,
              64'hDEADBEEF_00000001, 0, 64'hDEADBEEF_00000001};
    vt[1] = '{1, 1, 1, 2'd2, 58'h40, 3'd1, 64'h0, 1,
              64'h0000_0000_0000_00A5, 1, 64'h0000_0000_0000_00A5};
    vt[2] = '{1, 1, 1, 2'd1, 58'h41, 3'd7, 64'h0, 0,
              64'h0000_0000_0000_005A, 0, 64'h0000_0000_0000_005A};
    vt[3] = '{0, 1, 0, 2'd3, 58'h99, 3'd2,
              64'h11223344_55667788, 1,
              64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0000_0000_0000_00A5};
    vt[4] = '{1, 0, 0, 2'd1, 58'h7, 3'd0, 64'hCAFE, 0,
              64'h1234, 0, 64'h0000_0000_0000_005A};
    vt[5] = '{0, 1, 1, 2'd0, 58'h3FF, 3'd5, 64'h0, 0,
              64'h77, 1, 64'h77};

    reset = 0;
    r0_req = 0;
    r1_req = 0;
    set_fields('0, '0, '0, '0, 1'b1, '0);
    dc_ack = 0;
    dc_data_from_cache = '0;
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst grant_id", 64'(grant_id), 64'd1);
    chk("rst dc_rw", 64'(dc_read_write_n), 64'd1);
    reset = 1;
    cycle();

    foreach (vt[i]) run_vec(i, vt[i]);

    // Requester inputs change while the cache is busy
    set_fields(58'h10, 3'd1, 3'd0, '0, 1'b1, 2'd0);
    r0_req = 1;
    cycle();
    r0_line_addr = 58'h20;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold line_addr", 64'(dc_line_addr), 64'h10);
    end
    r0_req = 0;
    dc_ack = 1;
    dc_data_from_cache = 64'h0BAD_F00D;
    cycle();
    chk("drop req ack", 64'(r0_ack), 64'd1);
    dc_ack = 0;
    cycle();

    // Reset in the middle of a transaction
    r0_req = 1;
    cycle();
    cycle();
    #2 reset = 0;
    #1;
    chk("async rst dc_req", 64'(dc_req), 64'd0);
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst ack", 64'(r0_ack), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1;
    cycle();
    chk("post rst grant", 64'(dc_req), 64'd1);
    dc_ack = 1;
    dc_data_from_cache = 64'h5555_AAAA;
    cycle();
    chk("post rst ack", 64'(r0_ack), 64'd1);
    chk("post rst rdata", r0_rdata, 64'h5555_AAAA);
    r0_req = 0;
    dc_ack = 0;
    cycle();

`ifdef DC_TIMEOUT_EN
    r0_req = 1;
    cycle();
    for (int k = 0; k < 3; k++) cycle();
    chk("tmo early ack", 64'(r0_ack), 64'd0);
    cycle();
    chk("tmo err", 64'(err), 64'd1);
    chk("tmo ack", 64'(r0_ack), 64'd1);
    chk("tmo rdata", r0_rdata, 64'd0);
    r0_req = 0;
    cycle();
    r0_req = 1;
    cycle();
    for (int k = 0; k < 3; k++) cycle();
    dc_ack = 1;
    dc_data_from_cache = 64'hABCD;
    cycle();
    chk("tmo tie err", 64'(err), 64'd0);
    chk("tmo tie ack", 64'(r0_ack), 64'd1);
    chk("tmo tie rdata", r0_rdata, 64'hABCD);
    r0_req = 0;
    dc_ack = 0;
    cycle();
`endif

    for (int n = 0; n < 3000; n++) begin
      r0_req = ($urandom_range(0, 2) != 0);
      r1_req = ($urandom_range(0, 2) != 0);
      r0_line_addr = 58'({$urandom(), $urandom()});
      r1_line_addr = 58'({$urandom(), $urandom()});
      r0_word_select = 3'($urandom());
      r1_word_select = 3'($urandom());
      r0_byte_offset = 3'($urandom());
      r1_byte_offset = 3'($urandom());
      r0_wdata = {$urandom(), $urandom()};
      r1_wdata = {$urandom(), $urandom()};
      r0_read_write_n = 1'($urandom());
      r1_read_write_n = 1'($urandom());
      r0_store_type = 2'($urandom());
      r1_store_type = 2'($urandom());
      dc_ack = ($urandom_range(0, 2) == 0);
      dc_data_from_cache = {$urandom(), $urandom()};
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
